// File: rtl/dht11_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : dht11_responder
// Purpose : Device end of the DHT11 single-wire protocol. Detects a host start
//           request and answers with the response preamble and a 40-bit frame.
// Revision: 1.0 - initial release
// ============================================================================
module dht11_responder #(
    parameter int CLOCK_FREQ         = 100_000_000,
    parameter int START_MIN_US       = 18000,
    parameter int RESP_WAIT_US       = 30,
    parameter int RESP_LOW_US        = 80,
    parameter int RESP_HIGH_US       = 80,
    parameter int BIT_LOW_US         = 50,
    parameter int ZERO_HIGH_US       = 26,
    parameter int ONE_HIGH_US        = 70,
    parameter int RELEASE_TIMEOUT_US = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        data_in,
    output logic        data_drive_low,
    input  logic [7:0]  hum_int,
    input  logic [7:0]  hum_dec,
    input  logic [7:0]  temp_int,
    input  logic [7:0]  temp_dec,
    input  logic        bad_checksum,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int c_div   = CLOCK_FREQ / 1_000_000;
    localparam int c_div_w = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_div_w-1:0] c_div_max = c_div_w'(c_div - 1);

    localparam int c_max_us = f_max(f_max(f_max(START_MIN_US, RELEASE_TIMEOUT_US),
                                          f_max(RESP_WAIT_US, RESP_LOW_US)),
                                    f_max(f_max(RESP_HIGH_US, BIT_LOW_US),
                                          f_max(ZERO_HIGH_US, ONE_HIGH_US)));
    localparam int c_ph_w   = $clog2(c_max_us + 1);

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_HOST_LOW     = 4'd1,
        ST_WAIT_RELEASE = 4'd2,
        ST_RESP_WAIT    = 4'd3,
        ST_RESP_LOW     = 4'd4,
        ST_RESP_HIGH    = 4'd5,
        ST_BIT_LOW      = 4'd6,
        ST_BIT_HIGH     = 4'd7,
        ST_END_LOW      = 4'd8
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, line_q, line_prev_q;
    logic                fall_hold_q, fall_hold_d;
    logic [c_div_w-1:0]  tick_cnt_q, tick_cnt_d;
    logic [c_ph_w-1:0]   phase_q, phase_d;
    logic [39:0]         shift_q, shift_d;
    logic [5:0]          bit_cnt_q, bit_cnt_d;
    logic                data_drive_low_q, data_drive_low_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic [15:0]         frame_count_q, frame_count_d;

    logic                w_tick;
    logic                w_fall;
    logic [7:0]          w_sum;
    logic [7:0]          w_chk;

    // A phase of n us ends on the tick that would bring the counter to n.
    function automatic logic phase_end(input logic [c_ph_w-1:0] cnt, input int n);
        return (cnt == c_ph_w'(n - 1));
    endfunction

    assign w_tick = (tick_cnt_q == c_div_max);
    assign w_fall = line_prev_q & ~line_q;
    assign w_sum  = hum_int + hum_dec + temp_int + temp_dec;
    assign w_chk  = bad_checksum ? ~w_sum : w_sum;

    always_comb begin
        tick_cnt_d       = w_tick ? '0 : tick_cnt_q + 1'b1;
        state_d          = state_q;
        shift_d          = shift_q;
        bit_cnt_d        = bit_cnt_q;
        frame_done_d     = 1'b0;
        frame_count_d    = frame_count_q;

        case (state_q)
            ST_IDLE: begin
                if (w_fall || fall_hold_q) state_d = ST_HOST_LOW;
            end
            // The falling-edge cycle seen in IDLE already counts as the first us.
            ST_HOST_LOW: begin
                if (line_q)
                    state_d = ST_IDLE;
                else if (w_tick && phase_end(phase_q, START_MIN_US - 1))
                    state_d = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                if (line_q) begin
                    state_d   = ST_RESP_WAIT;
                    shift_d   = {hum_int, hum_dec, temp_int, temp_dec, w_chk};
                    bit_cnt_d = 6'd0;
                end else if (w_tick && phase_end(phase_q, RELEASE_TIMEOUT_US)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP_WAIT: begin
                if (w_tick && phase_end(phase_q, RESP_WAIT_US)) state_d = ST_RESP_LOW;
            end
            ST_RESP_LOW: begin
                if (w_tick && phase_end(phase_q, RESP_LOW_US)) state_d = ST_RESP_HIGH;
            end
            ST_RESP_HIGH: begin
                if (w_tick && phase_end(phase_q, RESP_HIGH_US)) state_d = ST_BIT_LOW;
            end
            ST_BIT_LOW: begin
                if (w_tick && phase_end(phase_q, BIT_LOW_US)) state_d = ST_BIT_HIGH;
            end
            ST_BIT_HIGH: begin
                if (w_tick && phase_end(phase_q, shift_q[39] ? ONE_HIGH_US : ZERO_HIGH_US)) begin
                    shift_d   = {shift_q[38:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    state_d   = (bit_cnt_q == 6'd39) ? ST_END_LOW : ST_BIT_LOW;
                end
            end
            ST_END_LOW: begin
                if (w_tick && phase_end(phase_q, BIT_LOW_US)) begin
                    state_d       = ST_IDLE;
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!enable) begin
            state_d       = ST_IDLE;
            frame_done_d  = 1'b0;
            frame_count_d = frame_count_q;
        end

        // Keep a falling edge that coincides with the return to IDLE.
        fall_hold_d = w_fall && (state_q != ST_IDLE) && (state_d == ST_IDLE);

        if ((state_d != state_q) || (state_q == ST_IDLE))
            phase_d = '0;
        else
            phase_d = phase_q + {{(c_ph_w-1){1'b0}}, w_tick};

        data_drive_low_d = (state_d == ST_RESP_LOW) || (state_d == ST_BIT_LOW) ||
                           (state_d == ST_END_LOW);
        busy_d           = (state_d != ST_IDLE) && (state_d != ST_HOST_LOW);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q          <= 1'b0;
            line_q           <= 1'b0;
            line_prev_q      <= 1'b0;
            fall_hold_q      <= 1'b0;
            tick_cnt_q       <= '0;
            phase_q          <= '0;
            state_q          <= ST_IDLE;
            shift_q          <= '0;
            bit_cnt_q        <= '0;
            data_drive_low_q <= 1'b0;
            busy_q           <= 1'b0;
            frame_done_q     <= 1'b0;
            frame_count_q    <= '0;
        end else begin
            sync1_q          <= data_in;
            line_q           <= sync1_q;
            line_prev_q      <= line_q;
            fall_hold_q      <= fall_hold_d;
            tick_cnt_q       <= tick_cnt_d;
            phase_q          <= phase_d;
            state_q          <= state_d;
            shift_q          <= shift_d;
            bit_cnt_q        <= bit_cnt_d;
            data_drive_low_q <= data_drive_low_d;
            busy_q           <= busy_d;
            frame_done_q     <= frame_done_d;
            frame_count_q    <= frame_count_d;
        end
    end

    assign data_drive_low = data_drive_low_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign frame_count    = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dht11_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_dht11_responder
// Purpose : Directed bench with a waveform-level model of the responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dht11_responder;

    localparam int START_MIN = 400;
    localparam int RESP_WAIT = 30;
    localparam int RESP_LOW  = 80;
    localparam int RESP_HIGH = 80;
    localparam int BIT_LOW   = 50;
    localparam int ZERO_H    = 26;
    localparam int ONE_H     = 70;
    localparam int TIMEOUT   = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        host_low = 1'b1;
    logic        data_in;
    logic        data_drive_low;
    logic [7:0]  hum_int = 8'h00, hum_dec = 8'h00, temp_int = 8'h00, temp_dec = 8'h00;
    logic        bad_checksum = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;

    assign data_in = ~host_low & ~data_drive_low;

    dht11_responder #(
        .CLOCK_FREQ(1_000_000), .START_MIN_US(START_MIN), .RESP_WAIT_US(RESP_WAIT),
        .RESP_LOW_US(RESP_LOW), .RESP_HIGH_US(RESP_HIGH), .BIT_LOW_US(BIT_LOW),
        .ZERO_HIGH_US(ZERO_H), .ONE_HIGH_US(ONE_H), .RELEASE_TIMEOUT_US(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .data_in(data_in),
        .data_drive_low(data_drive_low), .hum_int(hum_int), .hum_dec(hum_dec),
        .temp_int(temp_int), .temp_dec(temp_dec), .bad_checksum(bad_checksum),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_busy_from = -1, m_busy_to = -1, m_base = -1, m_cut = -1, m_done = -1;
    int          m_rel = -1;
    logic [39:0] m_frame = '0;
    logic [15:0] m_count = '0;
    int          hi_runs[$];
    int          first_rise = -1;
    int          run_len = 0;
    logic        prev_d = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [39:0] build_frame(input int a, input int b, input int c,
                                                 input int d, input bit bad);
        int s;
        s = (a + b + c + d) % 256;
        if (bad) s = 255 - s;
        return {a[7:0], b[7:0], c[7:0], d[7:0], s[7:0]};
    endfunction

    function automatic int high_len(input logic [39:0] f, input int i);
        return f[39 - i] ? ONE_H : ZERO_H;
    endfunction

    // Cycles from the start of the response low phase to the start of bit k's low phase.
    function automatic int bit_start(input logic [39:0] f, input int k);
        int t;
        t = RESP_LOW + RESP_HIGH;
        for (int i = 0; i < k; i++) t += BIT_LOW + high_len(f, i);
        return t;
    endfunction

    function automatic logic exp_drive(input int c);
        int s;
        if (m_base < 0 || c < m_base || (m_cut >= 0 && c >= m_cut)) return 1'b0;
        s = c - m_base;
        if (s < RESP_LOW) return 1'b1;
        s -= RESP_LOW;
        if (s < RESP_HIGH) return 1'b0;
        s -= RESP_HIGH;
        for (int i = 0; i < 40; i++) begin
            if (s < BIT_LOW) return 1'b1;
            s -= BIT_LOW;
            if (s < high_len(m_frame, i)) return 1'b0;
            s -= high_len(m_frame, i);
        end
        return (s < BIT_LOW);
    endfunction

    // Per-cycle comparison of every output against the model, plus a pulse-width monitor.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == m_done) m_count = m_count + 16'd1;
            chk("drive", data_drive_low, exp_drive(cyc));
            chk("busy", busy, (cyc >= m_busy_from && cyc < m_busy_to));
            chk("frame_done", frame_done, (cyc == m_done));
            chk("frame_count", frame_count, m_count);
            if (data_drive_low !== prev_d) begin
                if (data_drive_low === 1'b1) begin
                    if (busy === 1'b1 && prev_d === 1'b0) hi_runs.push_back(run_len);
                    if (first_rise < 0) first_rise = cyc;
                end
                run_len = 1;
            end else begin
                run_len++;
            end
            prev_d = data_drive_low;
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Host holds the line low for low_len cycles, then releases it.
    task automatic request(input int low_len);
        int f1;
        hi_runs.delete();
        first_rise = -1;
        @(negedge clk);
        f1 = cyc + 1;
        if (low_len >= START_MIN) begin
            m_rel       = f1 + low_len;
            m_busy_from = f1 + START_MIN + 1;
            m_base      = m_rel + 2 + RESP_WAIT;
            m_cut       = -1;
            m_frame     = build_frame(hum_int, hum_dec, temp_int, temp_dec, bad_checksum);
            m_busy_to   = m_base + bit_start(m_frame, 40) + BIT_LOW;
            m_done      = m_busy_to;
        end else begin
            m_busy_from = -1; m_busy_to = -1; m_base = -1; m_done = -1;
        end
        host_low = 1'b1;
        repeat (low_len) @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic check_decode(input string nm, input logic [39:0] lit);
        logic [39:0] got;
        got = '0;
        chk({nm, "_runs"}, hi_runs.size(), 42);
        if (hi_runs.size() == 42)
            for (int i = 0; i < 40; i++) got[39 - i] = (hi_runs[2 + i] > 48);
        chk({nm, "_bits"}, got, lit);
    endtask

    task automatic set_bytes(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d, input logic bad);
        hum_int = a; hum_dec = b; temp_int = c; temp_dec = d; bad_checksum = bad;
    endtask

    initial begin
        int a_cyc;
        // Line held low across reset release must not start a request.
        repeat (5) @(negedge clk);
        reset = 1'b0;
        wait_until(cyc + 2 * START_MIN);
        host_low = 1'b0;
        wait_until(cyc + 20);

        set_bytes(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
        request(START_MIN);
        wait_until(m_done + 20);
        chk("t1_latency", first_rise - m_rel, 32);
        chk("t1_resp_high", hi_runs.size() > 1 ? hi_runs[1] : -1, 80);
        check_decode("t1", 40'h37_00_19_05_55);
        chk("t1_count", frame_count, 16'd1);

        request(START_MIN - 1);
        wait_until(cyc + START_MIN + 100);
        chk("t2_no_busy", busy, 1'b0);
        set_bytes(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
        request(START_MIN);
        wait_until(m_done + 20);
        check_decode("t2", 40'h12_34_56_78_14);

        set_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        request(START_MIN);
        wait_until(m_done + 20);
        check_decode("t3", 40'hFF_FF_FF_FF_03);
        chk("t3_one_high", hi_runs.size() == 42 ? hi_runs[2] : -1, 70);
        chk("t3_zero_high", hi_runs.size() == 42 ? hi_runs[34] : -1, 26);
        chk("t3_last_high", hi_runs.size() == 42 ? hi_runs[41] : -1, 70);

        set_bytes(8'h10, 8'h20, 8'h30, 8'h40, 1'b0);
        request(START_MIN);
        wait_until(m_base + bit_start(m_frame, 3) + 10);
        hum_int = 8'h20;
        wait_until(m_done + 20);
        check_decode("t4", 40'h10_20_30_40_A0);
        chk("t4_count", frame_count, 16'd4);

        set_bytes(8'h5A, 8'hA5, 8'h0F, 8'hF0, 1'b0);
        request(START_MIN);
        a_cyc = m_base + bit_start(m_frame, 20) + BIT_LOW + 5;
        m_cut = a_cyc; m_busy_to = a_cyc; m_done = -1;
        wait_until(a_cyc - 1);
        enable = 1'b0;
        wait_until(a_cyc + 20);
        chk("t5_abort_count", frame_count, 16'd4);
        enable = 1'b1;
        wait_until(cyc + 10);
        request(START_MIN);
        wait_until(m_done + 20);
        check_decode("t5", 40'h5A_A5_0F_F0_FE);
        chk("t5_count", frame_count, 16'd5);

        // Host never releases: timeout back to IDLE, then no retrigger while still low.
        hi_runs.delete();
        @(negedge clk);
        m_busy_from = cyc + 1 + START_MIN + 1;
        m_busy_to   = m_busy_from + TIMEOUT;
        m_base = -1; m_done = -1;
        host_low = 1'b1;
        wait_until(m_busy_to + START_MIN + 50);
        chk("t6_timeout_busy", busy, 1'b0);
        host_low = 1'b0;
        wait_until(cyc + 20);
        chk("t6_count", frame_count, 16'd5);

        request(START_MIN);
        a_cyc = m_base + 10;
        wait_until(a_cyc - 1);
        reset = 1'b1;
        m_count = '0; m_cut = a_cyc; m_busy_to = a_cyc; m_done = -1;
        wait_until(a_cyc + 3);
        reset = 1'b0;
        wait_until(cyc + 20);
        chk("t6_reset_count", frame_count, 16'd0);
        chk("t6_reset_drive", data_drive_low, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
